csr_pwm_bank: RTL and testbench



---
 rtl/csr_pwm_pkg.sv | 28 ++
 rtl/pwm_channel.sv | 58 +++++
 rtl/csr_pwm_bank.sv | 140 ++++++++++++++
 tb/tb_csr_pwm_bank.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pwm_pkg.sv
// Shared constants for the CSR/PWM bank: opcodes, register map, CTRL bits, FSM states.
package csr_pwm_pkg;

    // Command opcodes in bits [7:6] of a command byte; 2'b11 also decodes as NOP.
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;

    // Register map.
    localparam int ADDR_CTRL    = 0;
    localparam int ADDR_CH_EN   = 1;
    localparam int ADDR_GPIO    = 2;
    localparam int ADDR_PWM_SEL = 3;
    localparam int ADDR_CH_BASE = 4;
    localparam int CH_STRIDE    = 4;

    // CTRL bit positions.
    localparam int CTRL_SOFT_RST = 0;
    localparam int CTRL_PWM_EN   = 1;
    localparam int CTRL_GPIO_EN  = 3;

    // Command FSM states.
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_WR_DATA = 1'b1
    } state_e;

endpackage

// File: rtl/pwm_channel.sv
// One 16-bit PWM channel: free-running counter, period/duty shadows, registered compare.
module pwm_channel (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        srst_i,
    input  logic        active_i,
    input  logic [15:0] period_i,
    input  logic [15:0] duty_i,
    output logic        cmp_o,
    output logic        pwm_o
);

    logic [15:0] cnt_q, cnt_d;
    logic [15:0] per_sh_q, per_sh_d;
    logic [15:0] duty_sh_q, duty_sh_d;
    logic        pwm_q;

    // Comparator; the parent also uses it so GPIO-routed PWM stays in phase with pwm_o.
    always_comb begin
        cmp_o = active_i && (cnt_q < duty_sh_q);
    end

    // Counter advance and shadow reload: shadows only follow the CSRs at wrap or while idle.
    always_comb begin
        cnt_d     = cnt_q;
        per_sh_d  = per_sh_q;
        duty_sh_d = duty_sh_q;
        if (!active_i) begin
            cnt_d     = 16'd0;
            per_sh_d  = period_i;
            duty_sh_d = duty_i;
        end else if (cnt_q == per_sh_q) begin
            cnt_d     = 16'd0;
            per_sh_d  = period_i;
            duty_sh_d = duty_i;
        end else begin
            cnt_d     = cnt_q + 16'd1;
        end
    end

    // Channel state registers, cleared by either hard or soft reset.
    always_ff @(posedge clk_i) begin
        if (rst_i || srst_i) begin
            cnt_q     <= 16'd0;
            per_sh_q  <= 16'd0;
            duty_sh_q <= 16'd0;
            pwm_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            per_sh_q  <= per_sh_d;
            duty_sh_q <= duty_sh_d;
            pwm_q     <= cmp_o;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/csr_pwm_bank.sv
// CSR bank fed by a byte command stream, driving N_CH PWM channels, a GPIO port and a soft reset.
module csr_pwm_bank
    import csr_pwm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 32,
    parameter int N_CH       = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  rx_valid_i,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_valid_o,
    output logic                  soft_rst_o,
    output logic [DATA_WIDTH-1:0] gpio_out_o,
    output logic [N_CH-1:0]       pwm_out_o
);

    localparam int                  IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] csr_q [DEPTH];
    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_valid_q;
    logic                  soft_rst_q;
    logic [DATA_WIDTH-1:0] gpio_q, gpio_d;

    logic [1:0]            op_s;
    logic [ADDR_WIDTH-1:0] cmd_addr_s;
    logic [N_CH-1:0]       cmp_s;
    logic [N_CH-1:0]       pwm_s;
    logic [DATA_WIDTH-1:0] sel_s;

    // Addresses at or above DEPTH are outside the array: writes drop, reads return zero.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    assign op_s       = rx_data_i[DATA_WIDTH-1 -: 2];
    assign cmd_addr_s = rx_data_i[ADDR_WIDTH-1:0];

    // Command FSM, CSR storage, read-back and soft-reset pulse generation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= {ADDR_WIDTH{1'b0}};
            tx_data_q  <= {DATA_WIDTH{1'b0}};
            tx_valid_q <= 1'b0;
            soft_rst_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) csr_q[i] <= {DATA_WIDTH{1'b0}};
        end else if (soft_rst_q) begin
            // Soft-reset cycle: everything returns to reset and the incoming byte is ignored.
            state_q    <= ST_IDLE;
            addr_q     <= {ADDR_WIDTH{1'b0}};
            tx_valid_q <= 1'b0;
            soft_rst_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) csr_q[i] <= {DATA_WIDTH{1'b0}};
        end else begin
            tx_valid_q <= 1'b0;
            soft_rst_q <= 1'b0;
            if (rx_valid_i) begin
                case (state_q)
                    ST_IDLE: begin
                        case (op_s)
                            OP_WR: begin
                                addr_q  <= cmd_addr_s;
                                state_q <= ST_WR_DATA;
                            end
                            OP_RD: begin
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= in_range(cmd_addr_s) ? csr_q[cmd_addr_s[IDX_W-1:0]]
                                                                   : {DATA_WIDTH{1'b0}};
                            end
                            default: begin
                                state_q <= ST_IDLE;
                            end
                        endcase
                    end
                    ST_WR_DATA: begin
                        state_q <= ST_IDLE;
                        if (in_range(addr_q)) begin
                            csr_q[addr_q[IDX_W-1:0]] <= rx_data_i;
                            if ((addr_q == ADDR_WIDTH'(ADDR_CTRL)) && rx_data_i[CTRL_SOFT_RST]) begin
                                soft_rst_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // One PWM channel per four-register slice of the map.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        localparam int B = ADDR_CH_BASE + CH_STRIDE * c;
        pwm_channel u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .srst_i   (soft_rst_q),
            .active_i (csr_q[ADDR_CTRL][CTRL_PWM_EN] && csr_q[ADDR_CH_EN][c]),
            .period_i ({csr_q[B], csr_q[B+1]}),
            .duty_i   ({csr_q[B+2], csr_q[B+3]}),
            .cmp_o    (cmp_s[c]),
            .pwm_o    (pwm_s[c])
        );
    end

    // GPIO next value: PWM override only exists on bits that have a channel behind them.
    always_comb begin
        sel_s = csr_q[ADDR_PWM_SEL] & DATA_WIDTH'({N_CH{1'b1}});
        if (csr_q[ADDR_CTRL][CTRL_GPIO_EN]) begin
            gpio_d = (sel_s & DATA_WIDTH'(cmp_s)) | (~sel_s & csr_q[ADDR_GPIO]);
        end else begin
            gpio_d = {DATA_WIDTH{1'b0}};
        end
    end

    // Registered GPIO port, aligned with the channel pwm registers.
    always_ff @(posedge clk_i) begin
        if (rst_i || soft_rst_q) begin
            gpio_q <= {DATA_WIDTH{1'b0}};
        end else begin
            gpio_q <= gpio_d;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign soft_rst_o = soft_rst_q;
    assign gpio_out_o = gpio_q;
    assign pwm_out_o  = pwm_s;

endmodule

// File: tb/tb_csr_pwm_bank.sv
// Self-checking bench for csr_pwm_bank: directed scenarios plus randomized CSR traffic.
module tb_csr_pwm_bank;

    localparam int         N_CH    = 4;
    localparam int         DEPTH   = 32;
    localparam logic [7:0] CH_MASK = 8'h0F;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       soft_rst;
    logic [7:0] gpio_out;
    logic [N_CH-1:0] pwm_out;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [64];
    logic       pend_v = 1'b0;
    logic [7:0] pend_d = 8'h00;

    csr_pwm_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(DEPTH), .N_CH(N_CH)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .soft_rst_o (soft_rst),
        .gpio_out_o (gpio_out),
        .pwm_out_o  (pwm_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic release_bus();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        drive({2'b10, 6'(a)});
        drive(d);
        release_bus();
    endtask

    task automatic rd_check(input int a, input logic [7:0] exp, input string name);
        drive({2'b01, 6'(a)});
        release_bus();
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== exp) begin
            miscompares++;
            $display("FAIL %s: tx_valid=%b tx_data=%h, expected 1 / %h", name, tx_valid, tx_data, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_valid = 1'b0;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    endtask

    // Check the read strobe that the previously driven byte should (or should not) produce.
    task automatic check_pend();
        vectors++;
        if (pend_v) begin
            if (tx_valid !== 1'b1 || tx_data !== pend_d) begin
                miscompares++;
                $display("FAIL rand_read: tx_valid=%b tx_data=%h, expected 1 / %h", tx_valid, tx_data, pend_d);
            end
        end else if (tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_no_read: tx_valid=%b, expected 0", tx_valid);
        end
    endtask

    task automatic send_chk(input logic [7:0] b, input logic rd, input logic [7:0] rd_exp);
        @(negedge clk);
        check_pend();
        rx_data  = b;
        rx_valid = 1'b1;
        pend_v   = rd;
        pend_d   = rd_exp;
    endtask

    task automatic flush();
        @(negedge clk);
        check_pend();
        rx_valid = 1'b0;
        pend_v   = 1'b0;
    endtask

    task automatic wait_rise(input int ch, input int budget, output logic found);
        logic prev;
        found = 1'b0;
        prev  = pwm_out[ch];
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (!prev && pwm_out[ch]) found = 1'b1;
            prev = pwm_out[ch];
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_rise ch%0d: no rising edge within %0d cycles", ch, budget);
        end
    endtask

    // Expected waveform: high for the first duty cycles of every (period+1)-cycle frame.
    task automatic check_pattern(input int ch, input int per, input int duty, input int n, input string name);
        logic found;
        logic exp;
        wait_rise(ch, 3 * (per + 1) + 4, found);
        if (found) begin
            for (int k = 0; k < n; k++) begin
                if (k > 0) @(negedge clk);
                exp = ((k % (per + 1)) < duty);
                vectors++;
                if (pwm_out[ch] !== exp) begin
                    miscompares++;
                    $display("FAIL %s k=%0d: pwm=%b, expected %b", name, k, pwm_out[ch], exp);
                end
            end
        end
    endtask

    task automatic check_const(input int ch, input logic lvl, input int n, input string name);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            vectors++;
            if (pwm_out[ch] !== lvl) begin
                miscompares++;
                $display("FAIL %s k=%0d: pwm=%b, expected %b", name, k, pwm_out[ch], lvl);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({tx_valid, tx_data, soft_rst, gpio_out, pwm_out} !== 22'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: tx_v=%b tx=%h srst=%b gpio=%h pwm=%h, expected all 0",
                     tx_valid, tx_data, soft_rst, gpio_out, pwm_out);
        end
        rd_check(0, 8'h00, "reset_ctrl");
        rd_check(31, 8'h00, "reset_scratch");
    endtask

    task automatic test_write_read();
        drive(8'h82);
        drive(8'hA5);
        drive(8'h42);
        release_bus();
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL read_after_write: tx_valid=%b tx_data=%h, expected 1 / a5", tx_valid, tx_data);
        end
        @(negedge clk);
        vectors++;
        if (tx_valid !== 1'b0 || tx_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL tx_hold: tx_valid=%b tx_data=%h, expected 0 / a5", tx_valid, tx_data);
        end
        rd_check(40, 8'h00, "read_oor");
        wr(40, 8'h77);
        rd_check(40, 8'h00, "write_oor_dropped");
        wr(31, 8'h5A);
        rd_check(31, 8'h5A, "scratch_top");
        rd_check(2, 8'hA5, "no_alias_from_oor");
    endtask

    task automatic test_random();
        int a;
        int last_wa;
        logic [7:0] d;
        logic [7:0] exp_g;
        do_reset();
        last_wa = 2;
        for (int b = 0; b < 4; b++) begin
            for (int t = 0; t < 20; t++) begin
                a = ($urandom_range(0, 1) == 1) ? last_wa : int'($urandom_range(0, 63));
                case ($urandom_range(0, 2))
                    0: begin
                        d = 8'($urandom);
                        if (a == 0) d = d & 8'hFC;
                        send_chk({2'b10, 6'(a)}, 1'b0, 8'h00);
                        send_chk(d, 1'b0, 8'h00);
                        if (a < DEPTH) mem[a] = d;
                        last_wa = a;
                    end
                    1: send_chk({2'b01, 6'(a)}, 1'b1, (a < DEPTH) ? mem[a] : 8'h00);
                    default: send_chk({($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00, 6'(a)}, 1'b0, 8'h00);
                endcase
            end
            flush();
            @(negedge clk);
            exp_g = mem[0][3] ? (mem[2] & ~(mem[3] & CH_MASK)) : 8'h00;
            vectors++;
            if (gpio_out !== exp_g || pwm_out !== 4'h0) begin
                miscompares++;
                $display("FAIL rand_gpio burst %0d: gpio=%h pwm=%h, expected %h / 0", b, gpio_out, pwm_out, exp_g);
            end
        end
    endtask

    task automatic test_gpio();
        do_reset();
        wr(0, 8'h08);
        drive(8'h82);
        drive(8'h3C);
        release_bus();
        vectors++;
        if (gpio_out !== 8'h00) begin
            miscompares++;
            $display("FAIL gpio_latency: gpio=%h one cycle after data, expected 00", gpio_out);
        end
        @(negedge clk);
        vectors++;
        if (gpio_out !== 8'h3C) begin
            miscompares++;
            $display("FAIL gpio_data: gpio=%h, expected 3c", gpio_out);
        end
        wr(0, 8'h00);
        @(negedge clk);
        vectors++;
        if (gpio_out !== 8'h00) begin
            miscompares++;
            $display("FAIL gpio_disable: gpio=%h, expected 00", gpio_out);
        end
    endtask

    task automatic test_pwm();
        do_reset();
        wr(5, 8'd9);
        wr(7, 8'd3);
        wr(1, 8'h01);
        wr(0, 8'h02);
        check_pattern(0, 9, 3, 30, "pwm_3_of_10");
    endtask

    task automatic test_shadow();
        logic found;
        logic exp;
        wait_rise(0, 40, found);
        if (found) begin
            for (int k = 0; k < 20; k++) begin
                if (k > 0) @(negedge clk);
                exp = (k < 10) ? (k < 3) : ((k - 10) < 7);
                vectors++;
                if (pwm_out[0] !== exp) begin
                    miscompares++;
                    $display("FAIL shadow k=%0d: pwm=%b, expected %b", k, pwm_out[0], exp);
                end
                if (k == 0) begin
                    rx_data = 8'h87; rx_valid = 1'b1;
                end else if (k == 1) begin
                    rx_data = 8'd7;  rx_valid = 1'b1;
                end else begin
                    rx_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic test_pwm_edges();
        wr(7, 8'd0);
        cycles(12);
        check_const(0, 1'b0, 20, "duty0_low");
        wr(7, 8'd10);
        cycles(12);
        check_const(0, 1'b1, 20, "duty_full_high");
        wr(5, 8'd0);
        cycles(12);
        check_const(0, 1'b1, 10, "period0_high");
        wr(7, 8'd0);
        cycles(3);
        check_const(0, 1'b0, 10, "period0_low");
    endtask

    task automatic test_pwm_sel();
        int highs;
        do_reset();
        wr(9, 8'd4);
        wr(11, 8'd2);
        wr(1, 8'h02);
        wr(3, 8'h02);
        wr(2, 8'h00);
        wr(0, 8'h0A);
        cycles(8);
        highs = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pwm_out[1]) highs++;
            vectors++;
            if (gpio_out !== (pwm_out[1] ? 8'h02 : 8'h00) || pwm_out[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL pwm_sel k=%0d: gpio=%h pwm=%h", k, gpio_out, pwm_out);
            end
        end
        vectors++;
        if (highs != 8) begin
            miscompares++;
            $display("FAIL pwm_sel_duty: %0d high cycles of 20, expected 8", highs);
        end
    endtask

    task automatic test_soft_reset();
        wr(20, 8'h55);
        drive(8'h80);
        drive(8'h01);
        @(negedge clk);
        vectors++;
        if (soft_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL soft_rst_pulse: soft_rst=%b, expected 1", soft_rst);
        end
        rx_data = 8'h82; rx_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (soft_rst !== 1'b0 || pwm_out !== 4'h0 || gpio_out !== 8'h00) begin
            miscompares++;
            $display("FAIL soft_rst_after: soft_rst=%b pwm=%h gpio=%h, expected 0/0/00", soft_rst, pwm_out, gpio_out);
        end
        rx_data = 8'h42; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL soft_rst_ignores_rx: tx_valid=%b tx_data=%h, expected 1 / 00", tx_valid, tx_data);
        end
        rd_check(0, 8'h00, "srst_ctrl");
        rd_check(1, 8'h00, "srst_ch_en");
        rd_check(3, 8'h00, "srst_pwm_sel");
        rd_check(9, 8'h00, "srst_ch1_period");
        rd_check(20, 8'h00, "srst_scratch");
        cycles(5);
        vectors++;
        if (pwm_out !== 4'h0 || gpio_out !== 8'h00 || soft_rst !== 1'b0) begin
            miscompares++;
            $display("FAIL srst_quiet: pwm=%h gpio=%h soft_rst=%b, expected 0", pwm_out, gpio_out, soft_rst);
        end
    endtask

    task automatic test_reset_mid_command();
        do_reset();
        drive(8'h82);
        @(negedge clk);
        rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(8'h42);
        release_bus();
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_mid_cmd: tx_valid=%b tx_data=%h, expected 1 / 00", tx_valid, tx_data);
        end
        rd_check(2, 8'h00, "rst_mid_cmd_no_write");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_random();
        test_gpio();
        test_pwm();
        test_shadow();
        test_pwm_edges();
        test_pwm_sel();
        test_soft_reset();
        test_reset_mid_command();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
